// File: rtl/mult_scheduler_pkg.sv
// Shared types and helpers for the multiplier scheduler: FSM state
// encoding, pick result struct and the round-robin search function.
package mult_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP,
    DRAIN
  } state_t;

  // Requester indices are sized for the largest supported configuration.
  localparam int MAX_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int DEF_W   = 16;
  localparam int PROD_W  = 2 * DEF_W;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request at or after ptr, wrapping modulo n_req.
  // The loop runs from the farthest offset down so the nearest one wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 n_req);
    pick_t          pick;
    logic [IDX_W:0] cand;
    pick = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n_req) begin
        cand = {1'b0, ptr} + (IDX_W + 1)'(k);
        if (cand >= (IDX_W + 1)'(n_req)) begin
          cand = cand - (IDX_W + 1)'(n_req);
        end
        if (req[cand[IDX_W-1:0]]) begin
          pick.found = 1'b1;
          pick.idx   = cand[IDX_W-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick from the current pointer, and a
// pointer that moves just past the served requester when adv pulses.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  input  logic [IDX_W-1:0] served_idx,
  output logic             found,
  output logic [IDX_W-1:0] pick_idx
);

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [MAX_REQ-1:0] req_ext;
  pick_t              pick;

  // Search the requests starting from the pointer position.
  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    pick                 = rr_pick(req_ext, ptr_q, N_REQ);
    found                = pick.found;
    pick_idx             = pick.idx;
  end

  // Next pointer is the requester after the one just served.
  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = (served_idx == IDX_W'(N_REQ - 1)) ? '0 : served_idx + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one multiplier core between N_REQ requesters: round-robin grant,
// operand latch, init/done handshake with a watchdog, and a drain state that
// keeps a lingering done from completing the following job.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] op_a,
  input  logic [N_REQ*W-1:0] op_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [2*W-1:0]     rsp_result,
  output logic               rsp_err,
  output logic               busy,
  output logic               mult_init,
  output logic [W-1:0]       mult_op_a,
  output logic [W-1:0]       mult_op_b,
  input  logic [2*W-1:0]     mult_result,
  input  logic               mult_done
);

  localparam int PW    = 2 * W;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [W-1:0]       op_a_q, op_a_d;
  logic [W-1:0]       op_b_q, op_b_d;
  logic               init_q, init_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]      rsp_result_q, rsp_result_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic               found;
  logic [IDX_W-1:0]   pick_idx;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .adv        (state_q == RESP),
    .served_idx (win_q),
    .found      (found),
    .pick_idx   (pick_idx)
  );

  // Next-state and next-output computation for the whole job sequence.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    win_d        = win_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    init_d       = init_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = '0;
    rsp_result_d = '0;
    rsp_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOAD;
          win_d   = pick_idx;
          gnt_d   = ONE << pick_idx;
          op_a_d  = op_a[int'(pick_idx)*W +: W];
          op_b_d  = op_b[int'(pick_idx)*W +: W];
        end
      end
      LOAD: begin
        init_d  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mult_done) begin
          state_d      = RESP;
          init_d       = 1'b0;
          rsp_valid_d  = gnt_q;
          rsp_result_d = mult_result;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = RESP;
          init_d      = 1'b0;
          rsp_valid_d = gnt_q;
          rsp_err_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = DRAIN;
        gnt_d   = '0;
      end
      DRAIN: begin
        if (!mult_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      win_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      init_q       <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      win_q        <= win_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      init_q       <= init_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign mult_init  = init_q;
  assign mult_op_a  = op_a_q;
  assign mult_op_b  = op_b_q;

endmodule

// File: doc/mult_scheduler.md
Name: mult_scheduler

Overview:
- Shares one 16x16 multiplier core (`mult`: init/done/result/op_A/op_B) between N_REQ requesters, e.g. the J1 CPU peripheral path and a DMA/accelerator port.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the init/done handshake of the core, with a timeout watchdog.
- Returns the 32-bit product to the granted requester only.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- W, 16, operand width; the product is 2*W.
- TIMEOUT, 64, maximum cycles in WAIT before the job is aborted (>=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester job request; level, held until its rsp_valid.
- op_a  in  N_REQ*W  packed operand A; slice i belongs to requester i.
- op_b  in  N_REQ*W  packed operand B.
- gnt  out  N_REQ  one-hot; the requester currently being served.
- rsp_valid  out  N_REQ  one-cycle pulse to the served requester.
- rsp_result  out  2*W  product; valid only while rsp_valid is nonzero.
- rsp_err  out  1  qualifies rsp_valid; 1 means a timeout abort, and rsp_result is then 0.
- busy  out  1  high in every state except IDLE.
- mult_init  out  1  to core init.
- mult_op_a  out  W  to core op_A.
- mult_op_b  out  W  to core op_B.
- mult_result  in  2*W  from core result.
- mult_done  in  1  from core done.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state=IDLE, rr_ptr=0, timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, LOAD, WAIT, RESP, DRAIN.

IDLE:
- If any req is high, pick the first set bit at or after rr_ptr, wrapping modulo N_REQ.
- Next edge: gnt=onehot(winner), latch op_a/op_b slices into mult_op_a/mult_op_b, go LOAD.
- No requests: stay in IDLE.

LOAD:
- mult_init=1, counter cleared, go WAIT.
- Operands are therefore stable at least one cycle before init rises.

WAIT:
- mult_init stays 1 and the counter increments each cycle.
- mult_done=1: capture mult_result, go RESP.
- Else counter==TIMEOUT-1: result=0, err=1, go RESP.
- mult_done wins if both conditions hold in the same cycle.

RESP (exactly 1 cycle):
- rsp_valid[winner]=1, rsp_result and rsp_err driven.
- mult_init=0.
- rr_ptr=(winner+1) mod N_REQ.
- Go DRAIN.

DRAIN:
- gnt=0, mult_init=0.
- Wait for mult_done=0, then go IDLE. This prevents a stale done from completing the next job.
- DRAIN has no timeout; a core stuck with done=1 is a system fault and busy stays high.

Operands and ownership:
- mult_op_a/mult_op_b hold their value from LOAD until the next LOAD; they are never changed while mult_init=1.
- Requesters may change op_a/op_b after gnt rises; the latched copy is used.

Request rules:
- A req dropping mid-job does not cancel the job; the response is still pulsed and ignored by that requester.
- Simultaneous requests: round-robin, so no requester waits more than N_REQ jobs.

Latency:
- The minimum from req to rsp_valid is core latency + 3 cycles: IDLE->LOAD, LOAD->WAIT, WAIT->RESP.
- The back-to-back job issue interval is core latency + 5 cycles.

Reset mid-job:
- Everything returns to reset values immediately and mult_init drops.
- No response is emitted for the aborted job.

Decomposition:
- Package mult_sched_pkg:
  - state enum {IDLE, LOAD, WAIT, RESP, DRAIN};
  - localparam PROD_W=2*W;
  - function rr_pick(req, ptr) returning the winner index plus a found flag.
- One natural sub-module is rr_arbiter: combinational round-robin pick plus the registered pointer update. Enable is the RESP pulse; it has its own async active-low reset.
- The FSM, operand latch and watchdog stay in mult_scheduler.

Test Plan:
- Single job: req[0]=1, op_a[0]=0x0003, op_b[0]=0x0005, core done after 16 cycles.
  - gnt=01 and mult_init=1 from the cycle after LOAD.
  - rsp_valid=01 with rsp_result=0x0000000F, rsp_err=0.
  - busy drops after done falls.
- Contention: req=11 held with rr_ptr=0; operands (0xFFFF,0xFFFF) and (0x1234,0x0002).
  - Grant order is 0,1,0,1.
  - Results are 0xFFFE0001 and 0x00002468, each delivered only on its own rsp_valid bit.
- Timeout: core done tied 0, TIMEOUT=64.
  - rsp_valid pulses exactly 64 cycles after entering WAIT, with rsp_err=1 and rsp_result=0.
  - The next job is served normally.
- Stale done: core holds done=1 for 5 cycles after init drops.
  - The FSM stays in DRAIN for those cycles.
  - The second job's LOAD occurs only after done=0.
  - The second job's result is correct, not the first job's.
- Mid-job reset: assert reset=0 during WAIT.
  - gnt, mult_init, busy and rsp_valid go 0 asynchronously and rr_ptr returns to 0.
  - After release, req=10 is granted to requester 1.
- Operand stability: change op_a[0] every cycle after gnt rises.
  - mult_op_a stays constant through WAIT.
  - The product uses the value sampled in IDLE.
